// File: rtl/jzjpcc_instruction_encoder.sv
// jzjpcc_instruction_encoder
// Packs decoded instruction fields and a full 32-bit immediate into RV32I
// instruction words. This is the inverse of decode-stage immediate extraction.
// A load-immediate (LI) request becomes one or two instructions: ADDI, LUI, or
// LUI followed by ADDI. An immediate that is out of range or misaligned for its
// format gives a single error beat instead of a corrupt encoding.
//
// Ports:
//   clock, reset_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready       request handshake
//   in_kind                   0=LI 1=OPIMM 2=STORE 3=BRANCH 4=JAL (5-7 reserved)
//   in_rd, in_rs1, in_rs2     register fields
//   in_funct3                 funct3 field, passed through unchanged
//   in_imm                    full signed immediate / constant / byte offset
//   out_valid / out_ready     output beat handshake
//   out_instr                 encoded instruction word (zero on error)
//   out_last                  final beat of the current request
//   out_error                 request rejected
//   beat_count                wrapping count of consumed output beats
module jzjpcc_instruction_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_kind,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_last,
    output logic               out_error,
    output logic [COUNT_W-1:0] beat_count
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_HOLD2 = 2'd2
    } state_t;

    state_t             state_r;
    logic               out_valid_r;
    logic [31:0]        out_instr_r;
    logic               out_last_r;
    logic               out_error_r;
    logic [31:0]        pend_r;
    logic [COUNT_W-1:0] beat_count_r;

    logic        accept_s;
    logic        out_fire_s;
    logic        fits12_s;
    logic        fits13_s;
    logic        fits21_s;
    logic [31:0] lui_round_s;
    logic [31:0] enc_first_s;
    logic [31:0] enc_second_s;
    logic        enc_two_s;
    logic        enc_err_s;

    assign out_valid  = out_valid_r;
    assign out_instr  = out_instr_r;
    assign out_last   = out_last_r;
    assign out_error  = out_error_r;
    assign beat_count = beat_count_r;

    // A new request may enter when the output is empty or its final beat leaves now.
    assign in_ready   = ~out_valid_r | (out_ready & out_last_r);
    assign accept_s   = in_valid & in_ready;
    assign out_fire_s = out_valid_r & out_ready;

    // A value fits an N-bit signed field when all bits from N-1 upward agree.
    assign fits12_s = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign fits13_s = (&in_imm[31:12]) | ~(|in_imm[31:12]);
    assign fits21_s = (&in_imm[31:20]) | ~(|in_imm[31:20]);

    // Rounding the upper part up by 0x800 cancels the sign extension of the ADDI low part.
    assign lui_round_s = in_imm + 32'h0000_0800;

    // Encode the request fields into the first beat and an optional second LI beat.
    always_comb begin
        enc_first_s  = 32'h0000_0000;
        enc_second_s = 32'h0000_0000;
        enc_two_s    = 1'b0;
        enc_err_s    = 1'b0;
        case (in_kind)
            3'd0: begin
                if (fits12_s) begin
                    enc_first_s = {in_imm[11:0], 5'd0, 3'b000, in_rd, OPC_OPIMM};
                end else if (in_imm[11:0] == 12'h000) begin
                    enc_first_s = {in_imm[31:12], in_rd, OPC_LUI};
                end else begin
                    enc_first_s  = {lui_round_s[31:12], in_rd, OPC_LUI};
                    enc_second_s = {in_imm[11:0], in_rd, 3'b000, in_rd, OPC_OPIMM};
                    enc_two_s    = 1'b1;
                end
            end
            3'd1: begin
                if (fits12_s) begin
                    enc_first_s = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_OPIMM};
                end else begin
                    enc_err_s = 1'b1;
                end
            end
            3'd2: begin
                if (fits12_s) begin
                    enc_first_s = {in_imm[11:5], in_rs2, in_rs1, in_funct3,
                                   in_imm[4:0], OPC_STORE};
                end else begin
                    enc_err_s = 1'b1;
                end
            end
            3'd3: begin
                if (fits13_s && (in_imm[0] == 1'b0)) begin
                    enc_first_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                   in_imm[4:1], in_imm[11], OPC_BRANCH};
                end else begin
                    enc_err_s = 1'b1;
                end
            end
            3'd4: begin
                if (fits21_s && (in_imm[0] == 1'b0)) begin
                    enc_first_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                   in_rd, OPC_JAL};
                end else begin
                    enc_err_s = 1'b1;
                end
            end
            default: begin
                enc_err_s = 1'b1;
            end
        endcase
    end

    // Output register, pending LI beat, state machine and consumed-beat counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            out_valid_r  <= 1'b0;
            out_instr_r  <= 32'h0000_0000;
            out_last_r   <= 1'b0;
            out_error_r  <= 1'b0;
            pend_r       <= 32'h0000_0000;
            beat_count_r <= {COUNT_W{1'b0}};
        end else begin
            if (out_fire_s) begin
                beat_count_r <= beat_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
            end else begin
                beat_count_r <= beat_count_r;
            end

            if (accept_s) begin
                out_valid_r <= 1'b1;
                out_instr_r <= enc_first_s;
                out_last_r  <= ~enc_two_s;
                out_error_r <= enc_err_s;
                pend_r      <= enc_second_s;
                state_r     <= enc_two_s ? ST_HOLD2 : ST_HOLD;
            end else if (out_fire_s) begin
                case (state_r)
                    ST_HOLD2: begin
                        out_instr_r <= pend_r;
                        out_last_r  <= 1'b1;
                        out_error_r <= 1'b0;
                        state_r     <= ST_HOLD;
                    end
                    default: begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_jzjpcc_instruction_encoder.sv
module tb_jzjpcc_instruction_encoder;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_kind = 3'd0;
    logic [4:0]    in_rd = 5'd0;
    logic [4:0]    in_rs1 = 5'd0;
    logic [4:0]    in_rs2 = 5'd0;
    logic [2:0]    in_funct3 = 3'd0;
    logic [31:0]   in_imm = 32'd0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [31:0]   out_instr;
    logic          out_last;
    logic          out_error;
    logic [CW-1:0] beat_count;

    jzjpcc_instruction_encoder #(.COUNT_W(CW)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_last(out_last), .out_error(out_error), .beat_count(beat_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] instr;
        logic        last;
        logic        err;
    } beat_t;

    beat_t         sb[$];
    beat_t         dir[$];
    int            tests = 0;
    int            fails = 0;
    logic [CW-1:0] cnt_m = '0;
    int            rdy_mode = 1;

    function automatic beat_t mk(input logic [31:0] i, input logic l, input logic e);
        beat_t b;
        b.instr = i; b.last = l; b.err = e;
        return b;
    endfunction

    // Reference model: builds expected beats with arithmetic on the immediate.
    function automatic void model(input logic [2:0] k, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [2:0] f3, input logic [31:0] imm);
        int s;
        logic [31:0] r, up;
        s = $signed(imm);
        case (k)
            3'd0: begin
                if (s >= -2048 && s <= 2047)
                    sb.push_back(mk(((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13, 1'b1, 1'b0));
                else if ((imm % 32'd4096) == 32'd0)
                    sb.push_back(mk((imm & 32'hFFFFF000) | (32'(rd) << 7) | 32'h37, 1'b1, 1'b0));
                else begin
                    up = (imm + 32'd2048) & 32'hFFFFF000;
                    sb.push_back(mk(up | (32'(rd) << 7) | 32'h37, 1'b0, 1'b0));
                    sb.push_back(mk(((imm & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13,
                                    1'b1, 1'b0));
                end
            end
            3'd1: begin
                if (s >= -2048 && s <= 2047)
                    sb.push_back(mk(((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                                    | (32'(rd) << 7) | 32'h13, 1'b1, 1'b0));
                else sb.push_back(mk(32'd0, 1'b1, 1'b1));
            end
            3'd2: begin
                if (s >= -2048 && s <= 2047)
                    sb.push_back(mk((((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                                    | (32'(f3) << 12) | ((imm & 32'h1F) << 7) | 32'h23, 1'b1, 1'b0));
                else sb.push_back(mk(32'd0, 1'b1, 1'b1));
            end
            3'd3: begin
                if (s >= -4096 && s <= 4094 && (s % 2) == 0) begin
                    r = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                      | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12)
                      | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | 32'h63;
                    sb.push_back(mk(r, 1'b1, 1'b0));
                end else sb.push_back(mk(32'd0, 1'b1, 1'b1));
            end
            3'd4: begin
                if (s >= -1048576 && s <= 1048574 && (s % 2) == 0) begin
                    r = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                      | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                      | (32'(rd) << 7) | 32'h6F;
                    sb.push_back(mk(r, 1'b1, 1'b0));
                end else sb.push_back(mk(32'd0, 1'b1, 1'b1));
            end
            default: sb.push_back(mk(32'd0, 1'b1, 1'b1));
        endcase
    endfunction

    // Monitor: compares the presented beat against the scoreboard head every cycle.
    always @(negedge clock) begin
        tests++;
        if (out_valid !== (sb.size() != 0)) begin
            fails++;
            $display("FAIL valid: out_valid=%b expected=%b", out_valid, (sb.size() != 0));
        end
        tests++;
        if (beat_count !== cnt_m) begin
            fails++;
            $display("FAIL beat_count: got %0d expected %0d", beat_count, cnt_m);
        end
        if (out_valid && sb.size() != 0) begin
            tests++;
            if (out_instr !== sb[0].instr || out_last !== sb[0].last || out_error !== sb[0].err) begin
                fails++;
                $display("FAIL beat: instr=%h last=%b err=%b expected instr=%h last=%b err=%b",
                         out_instr, out_last, out_error, sb[0].instr, sb[0].last, sb[0].err);
            end
            tests++;
            if (in_ready !== (out_ready & sb[0].last)) begin
                fails++;
                $display("FAIL in_ready_busy: got %b expected %b", in_ready, out_ready & sb[0].last);
            end
            if (out_ready) begin
                void'(sb.pop_front());
                cnt_m = cnt_m + 1'b1;
            end
        end else if (!out_valid) begin
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL in_ready_idle: got %b expected 1", in_ready);
            end
        end
    end

    // Output-ready driver.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    task automatic send(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm);
        logic acc;
        int n;
        in_kind = k; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_funct3 = f3; in_imm = imm;
        in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 1000) begin
            @(negedge clock);
            acc = in_ready;
            @(posedge clock);
            n++;
        end
        if (!acc) begin
            tests++; fails++;
            $display("FAIL accept_timeout: accepted=0 expected=1");
        end else if (dir.size() != 0) begin
            foreach (dir[i]) sb.push_back(dir[i]);
            dir.delete();
        end else begin
            model(k, rd, rs1, rs2, f3, imm);
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: pending=%0d expected=0", sb.size());
            sb.delete();
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        cnt_m = '0;
        @(posedge clock);
        #1;
        tests++;
        if (out_valid !== 1'b0 || beat_count !== '0 || out_instr !== 32'd0
            || out_last !== 1'b0 || out_error !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: valid=%b count=%0d instr=%h last=%b err=%b expected all zero",
                     out_valid, beat_count, out_instr, out_last, out_error);
        end
        @(posedge clock);
        #2;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    int bnd[17] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4098,
                    1048574, 1048576, -1048576, -1048578,
                    32'h7FFFF800, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFF800};

    initial begin
        logic [31:0] imm, rv;
        do_reset();

        // Directed vectors with hand-derived encodings.
        rdy_mode = 1;
        dir.push_back(mk(32'h06400093, 1'b1, 1'b0));
        send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 32'd100);
        dir.push_back(mk(32'h00001137, 1'b1, 1'b0));
        send(3'd0, 5'd2, 5'd0, 5'd0, 3'd0, 32'h00001000);
        drain();
        rdy_mode = 0;
        dir.push_back(mk(32'h123462B7, 1'b0, 1'b0));
        dir.push_back(mk(32'hFFF28293, 1'b1, 1'b0));
        send(3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
        repeat (4) @(posedge clock);
        #1;
        rdy_mode = 1;
        drain();
        dir.push_back(mk(32'h00208463, 1'b1, 1'b0));
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'd8);
        dir.push_back(mk(32'h00000000, 1'b1, 1'b1));
        send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
        dir.push_back(mk(32'h001000EF, 1'b1, 1'b0));
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        dir.push_back(mk(32'h00000000, 1'b1, 1'b1));
        send(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00100000);
        drain();

        // Streaming single-beat requests from a fresh counter, then wrap.
        do_reset();
        for (int i = 0; i < 10; i++) send(3'd1, 5'(i), 5'(i + 1), 5'd0, 3'(i), 32'(i * 37));
        drain();
        tests++;
        if (beat_count !== 4'd10) begin
            fails++;
            $display("FAIL stream_count: got %0d expected 10", beat_count);
        end
        for (int i = 0; i < 7; i++) send(3'd0, 5'(i + 3), 5'd0, 5'd0, 3'd0, 32'(i - 3));
        drain();
        tests++;
        if (beat_count !== 4'd1) begin
            fails++;
            $display("FAIL wrap_count: got %0d expected 1", beat_count);
        end

        // Reset after the first LI beat is consumed: second beat must never appear.
        rdy_mode = 0;
        send(3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
        rdy_mode = 1;
        begin
            int n;
            n = 0;
            while (sb.size() != 1 && n < 100) begin
                @(negedge clock);
                n++;
            end
        end
        do_reset();
        repeat (5) @(posedge clock);
        #1;

        // Randomized traffic with random back-pressure.
        rdy_mode = 2;
        for (int i = 0; i < 300; i++) begin
            rv = $urandom;
            case ($urandom_range(0, 5))
                0: imm = 32'(int'($urandom_range(0, 4095)) - 2048);
                1: imm = $urandom;
                2: imm = {rv[19:0], 12'h000};
                3: imm = 32'(bnd[$urandom_range(0, 16)]);
                4: imm = 32'(int'($urandom_range(0, 2097151)) - 1048576);
                default: imm = 32'(int'($urandom_range(0, 8191)) - 4096);
            endcase
            send(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), imm);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/jzjpcc_instruction_encoder.md
Name: jzjpcc_instruction_encoder

Overview:
Packs decoded instruction fields plus a full 32-bit immediate back into RV32I instruction words. It is the inverse of the decode-stage immediate extraction.
Used by the debug/program-buffer path and by the self-test sequencer to synthesise instructions on the fly.
Load-immediate (LI) requests expand into one or two instructions (ADDI, LUI, or LUI+ADDI).
Out-of-range or misaligned immediates yield an error beat instead of a corrupt encoding.

Parameters:
COUNT_W, 16, width of the wrapping emitted-beat counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid & in_ready
in_kind  in  3  0=LI, 1=OPIMM, 2=STORE, 3=BRANCH, 4=JAL; 5-7 reserved
in_rd  in  5  destination register (LI, OPIMM, JAL)
in_rs1  in  5  source 1 (OPIMM, STORE, BRANCH)
in_rs2  in  5  source 2 (STORE, BRANCH)
in_funct3  in  3  funct3 (OPIMM, STORE, BRANCH)
in_imm  in  32  full signed immediate / constant / byte offset
out_valid  out  1  output beat valid
out_ready  in  1  output beat consumed when out_valid & out_ready
out_instr  out  32  encoded instruction word
out_last  out  1  final beat of the current request
out_error  out  1  request rejected; out_instr = 32'h00000000
beat_count  out  COUNT_W  number of consumed output beats, wraps

Behaviour:
- Reset (async, reset_n low):
  - out_valid=0, out_instr=0, out_last=0, out_error=0, beat_count=0.
  - Pending second beat discarded; state=IDLE.
  - In-flight requests are lost.
- States:
  - IDLE: output register empty.
  - HOLD: one beat presented; no second beat pending.
  - HOLD2: first LI beat presented; ADDI beat pending in an internal register.
- in_ready = !out_valid | (out_ready & out_last). Back-to-back requests sustain 1 beat/cycle with zero bubble.
- Latency: accepted request appears on out_* the next cycle (registered outputs).
- Transitions:
  - Accept → HOLD, or HOLD2 when LI needs two beats.
  - HOLD2 & out_ready → load pending beat, with out_last=1 → HOLD.
  - HOLD & out_ready & no new accept → IDLE.
- Stability: out_instr, out_last and out_error stay stable while out_valid & !out_ready.
- LI encoding:
  - imm in [-2048,2047]: single ADDI rd,x0,imm.
  - else if imm[11:0]==0: single LUI rd,imm[31:12].
  - else two beats:
    - beat 1: LUI rd,U with U=(imm+32'h800)[31:12], modulo 2^32.
    - beat 2: ADDI rd,rd,imm[11:0], sign-extended.
  - Any 32-bit value is legal for LI; LI never errors.
- OPIMM: I-type, opcode 0010011. Imm must be in [-2048,2047]. funct3 passed through unchanged (shift funct7 is the caller's job via imm[11:5]).
- STORE: S-type, opcode 0100011. Imm must be in [-2048,2047].
- BRANCH: B-type, opcode 1100011. Imm must be even and in [-4096,4094].
- JAL: J-type, opcode 1101111. Imm must be even and in [-1048576,1048574].
- Range check: signed compare on in_imm. Violation or reserved kind → single beat with out_error=1, out_last=1, out_instr=0.
- Only beats with out_last=1 finish a request.
- beat_count increments on every consumed beat, including error beats. Wraps 2^COUNT_W-1 → 0.
- in_valid while !in_ready: request ignored. The upstream holds its fields stable until accepted.

Test Plan:
- LI rd=1, imm=100 → one beat 0x06400093, last=1, error=0.
- LI rd=2, imm=0x00001000 → one beat 0x00001137, last=1.
- LI rd=5, imm=0x12345FFF → beats 0x123462B7 (last=0), then 0xFFF28293 (last=1). Hold out_ready low 3 cycles between beats → beat 1 stable, in_ready=0.
- BRANCH funct3=0, rs1=1, rs2=2, imm=8 → 0x00208463. Then BRANCH imm=3 → out_instr=0, error=1, last=1.
- JAL rd=1, imm=2048 → 0x001000EF. Then JAL imm=0x00100000 → error beat.
- Streaming 10 single-beat requests with out_ready=1 → 10 beats on 10 consecutive cycles, beat_count=10.
- reset_n low mid-LI (after beat 1 only) → out_valid=0, beat_count=0, no beat 2 after release.
- COUNT_W=4 with 17 beats → beat_count=1.
